aes_result_collector: RTL and testbench

AES_RESULT_COLLECTOR -- requirements
Module: aes_result_collector

---
 rtl/aes_result_collector.sv | 108 ++++++++++
 tb/tb_aes_result_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_collector.sv
// Collects ciphertexts from a fixed-latency aes_128 core into a credit-protected result FIFO.
// Optional feature: define AES_COLLECTOR_TAG_EN to carry an 8-bit tag alongside each launch.
module aes_result_collector #(
    parameter int LATENCY = 21,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         launch,
    output logic         launch_ready,
    input  logic [127:0] aes_out,
    output logic [127:0] ct_data,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [4:0]   inflight,
    output logic         drop_err
`ifdef AES_COLLECTOR_TAG_EN
    ,
    input  logic [7:0]   launch_tag,
    output logic [7:0]   ct_tag
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LATENCY-1:0] valid_sr;
    logic [127:0]       mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [5:0]         credits_used;
    logic               accept;
    logic               capture;
    logic               pop;

    // Every in-flight launch holds a reserved FIFO slot, so a capture never meets a full FIFO.
    assign credits_used = 6'(inflight) + 6'(count);
    assign launch_ready = (credits_used < 6'(DEPTH));
    assign accept       = launch & launch_ready;
    assign capture      = valid_sr[LATENCY-1];
    assign ct_valid     = (count != '0);
    assign pop          = ct_valid & ct_ready;
    assign ct_data      = ct_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr <= '0;
            inflight <= '0;
            drop_err <= 1'b0;
        end else begin
            valid_sr <= {valid_sr[LATENCY-2:0], accept};
            case ({accept, capture})
                2'b10:   inflight <= inflight + 5'd1;
                2'b01:   inflight <= inflight - 5'd1;
                default: inflight <= inflight;
            endcase
            if (launch && !launch_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Pointers are AW bits wide with DEPTH a power of two, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            mem[wr_ptr] <= aes_out;
        end
    end

`ifdef AES_COLLECTOR_TAG_EN
    logic [7:0] tag_sr  [LATENCY];
    logic [7:0] tag_mem [DEPTH];

    // The tag pipeline shifts every cycle, so a tag stays aligned with its launch's valid bit.
    always_ff @(posedge clk) begin
        tag_sr[0] <= launch_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_sr[i] <= tag_sr[i-1];
        end
        if (!reset && capture) begin
            tag_mem[wr_ptr] <= tag_sr[LATENCY-1];
        end
    end

    assign ct_tag = ct_valid ? tag_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_aes_result_collector.sv
// Scoreboard bench for aes_result_collector: a behavioural aes_128 delay model feeds aes_out,
// expected ciphertexts are queued at launch time and a negedge monitor checks each pop.
module tb_aes_result_collector;

    localparam int LATENCY = 21;
    localparam int DEPTH   = 4;

    localparam logic [127:0] CT_A = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_B = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         launch;
    logic         launch_ready;
    logic [127:0] aes_out;
    logic [127:0] ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic [4:0]   inflight;
    logic         drop_err;
    logic [7:0]   launch_tag;
    logic [127:0] cur_ct;
`ifdef AES_COLLECTOR_TAG_EN
    logic [7:0]   ct_tag;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] ct;
        logic [7:0]   tag;
    } exp_t;
    exp_t exp_q[$];

    logic [127:0] core_pipe [LATENCY];

    aes_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .launch       (launch),
        .launch_ready (launch_ready),
        .aes_out      (aes_out),
        .ct_data      (ct_data),
        .ct_valid     (ct_valid),
        .ct_ready     (ct_ready),
        .inflight     (inflight),
        .drop_err     (drop_err)
`ifdef AES_COLLECTOR_TAG_EN
        ,
        .launch_tag   (launch_tag),
        .ct_tag       (ct_tag)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural aes_128 core: the ciphertext of a vector applied on an edge appears on
    // aes_out exactly LATENCY edges later; every other slot carries random junk.
    always @(posedge clk) begin
        core_pipe[0] <= launch ? cur_ct : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < LATENCY; i++) begin
            core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign aes_out = core_pipe[LATENCY-1];

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!reset && ct_valid && ct_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got %h expected none", ct_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("ct_data", ct_data, e.ct);
`ifdef AES_COLLECTOR_TAG_EN
                checkOutput("ct_tag", {120'b0, ct_tag}, {120'b0, e.tag});
`endif
            end
        end
    end

    task automatic applyStimulus(input logic l, input logic [127:0] ct, input logic [7:0] tag,
                                 input logic exp_ready, input logic push);
        exp_t e;
        launch     = l;
        cur_ct     = ct;
        launch_tag = tag;
        checkOutput("launch_ready", {127'b0, launch_ready}, {127'b0, exp_ready});
        if (push) begin
            e.ct  = ct;
            e.tag = tag;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        launch = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitValid(input int limit, output int n);
        launch = 1'b0;
        n = -1;
        for (int i = 0; i <= limit; i++) begin
            @(negedge clk);
            if (ct_valid) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_valid: got timeout expected ct_valid within %0d cycles", limit);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int valid_seen;
        logic [127:0] v;

        reset = 1'b1; launch = 1'b0; ct_ready = 1'b0; cur_ct = '0; launch_tag = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_launch_ready", {127'b0, launch_ready}, 128'd1);
        checkOutput("rst_ct_valid", {127'b0, ct_valid}, 128'd0);
        checkOutput("rst_ct_data", ct_data, 128'd0);
        checkOutput("rst_inflight", {123'b0, inflight}, 128'd0);
        checkOutput("rst_drop_err", {127'b0, drop_err}, 128'd0);

        // Single launch: first valid sample is LATENCY negedges after the launch edge
        ct_ready = 1'b1;
        applyStimulus(1'b1, CT_A, 8'h01, 1'b1, 1'b1);
        checkOutput("inflight_one", {123'b0, inflight}, 128'd1);
        waitValid(LATENCY + 10, n);
        checkOutput("latency", 128'(n), 128'(LATENCY));
        idleCycles(5);

        // Back-to-back launches emerge on consecutive cycles
        applyStimulus(1'b1, CT_A, 8'h02, 1'b1, 1'b1);
        applyStimulus(1'b1, CT_B, 8'h03, 1'b1, 1'b1);
        waitValid(LATENCY + 10, n);
        @(negedge clk);
        checkOutput("second_consecutive", {127'b0, ct_valid}, 128'd1);
        idleCycles(5);
        checkOutput("drained_valid", {127'b0, ct_valid}, 128'd0);

        // Launch held for 10 cycles with a stalled consumer: only DEPTH accepted
        ct_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            v = {4{32'hC0DE0000 + 32'(k)}};
            applyStimulus(1'b1, v, 8'(8'h10 + k), (k < DEPTH), (k < DEPTH));
        end
        launch = 1'b0;
        checkOutput("drop_err_set", {127'b0, drop_err}, 128'd1);
        checkOutput("inflight_full", {123'b0, inflight}, 128'd4);
        idleCycles(LATENCY + 4);
        checkOutput("inflight_landed", {123'b0, inflight}, 128'd0);
        checkOutput("full_valid", {127'b0, ct_valid}, 128'd1);
        checkOutput("hold_data_a", ct_data, {4{32'hC0DE0000}});
        idleCycles(3);
        checkOutput("hold_data_b", ct_data, {4{32'hC0DE0000}});
        checkOutput("full_not_ready", {127'b0, launch_ready}, 128'd0);

        // Full FIFO: pop on the same edge as a launch attempt, then launch into the freed credit
        ct_ready = 1'b1;
        applyStimulus(1'b1, 128'hD00DD00DD00DD00DD00DD00DD00DD00D, 8'h20, 1'b0, 1'b0);
        ct_ready = 1'b0;
        applyStimulus(1'b1, 128'hD00DD00DD00DD00DD00DD00DD00DD00D, 8'h20, 1'b1, 1'b1);
        idleCycles(LATENCY + 2);
        checkOutput("refill_inflight", {123'b0, inflight}, 128'd0);
        checkOutput("refill_full", {127'b0, launch_ready}, 128'd0);
        checkOutput("refill_head", ct_data, {4{32'hC0DE0001}});
        ct_ready = 1'b1;
        idleCycles(8);
        checkOutput("refill_drained", {127'b0, ct_valid}, 128'd0);

        // Reset during operation discards in-flight launches
        applyStimulus(1'b1, {4{32'hEEEE0000}}, 8'h30, 1'b1, 1'b0);
        applyStimulus(1'b1, {4{32'hEEEE0001}}, 8'h31, 1'b1, 1'b0);
        applyStimulus(1'b1, {4{32'hEEEE0002}}, 8'h32, 1'b1, 1'b0);
        idleCycles(10);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("post_rst_inflight", {123'b0, inflight}, 128'd0);
        checkOutput("post_rst_drop_err", {127'b0, drop_err}, 128'd0);
        checkOutput("post_rst_ready", {127'b0, launch_ready}, 128'd1);
        valid_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ct_valid) valid_seen++;
        end
        checkOutput("post_rst_no_valid", 128'(valid_seen), 128'd0);

        checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
